cardinal_fwd_scoreboard: RTL

//  Parametrised hazard/forwarding unit for the cardinal vector pipeline (ID stage).
//  Per-register, per-lane scoreboard of in-flight writes:
//   - stalls issue on unresolved load latency;
//   - merges EX/WB bypass data into up to NSRC operands at lane granularity, honouring PPP partial writes.

---
 rtl/cardinal_fwd_scoreboard_pkg.sv | 36 +++
 rtl/cardinal_fwd_scoreboard_if.sv | 49 ++++
 rtl/cardinal_fwd_scoreboard_lane_fwd_mux.sv | 51 +++++
 rtl/cardinal_fwd_scoreboard.sv | 113 +++++++++++
 4 files changed

// File: rtl/cardinal_fwd_scoreboard_pkg.sv
// Shared encodings and lane-mask helper for the cardinal ID-stage hazard/forwarding unit.
package cardinal_pkg;

    localparam logic [2:0] PPP_ALL   = 3'b000;
    localparam logic [2:0] PPP_UPPER = 3'b001;
    localparam logic [2:0] PPP_LOWER = 3'b010;
    localparam logic [2:0] PPP_EVEN  = 3'b011;
    localparam logic [2:0] PPP_ODD   = 3'b100;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    localparam int MAX_LANES = 64;
    // Wide enough for 1 + LD_LAT with LD_LAT up to 7
    localparam int CNT_W     = 4;

    // Bit l of the result is lane l; lane 0 is the most significant lane of the operand.
    function automatic logic [MAX_LANES-1:0] ppp_lane_mask(input logic [2:0] ppp, input int lanes);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int l = 0; l < MAX_LANES; l++) begin
            if (l < lanes) begin
                case (ppp)
                    PPP_UPPER: m[l] = (l < lanes / 2);
                    PPP_LOWER: m[l] = (l >= lanes / 2);
                    PPP_EVEN:  m[l] = ((l % 2) == 0);
                    PPP_ODD:   m[l] = ((l % 2) == 1);
                    default:   m[l] = 1'b1;
                endcase
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/cardinal_fwd_scoreboard_if.sv
// ID/EX/WB bundle of the forwarding scoreboard; i_/o_ names are from the scoreboard's view.
interface cardinal_fwd_scoreboard_if #(
    parameter int DATA_W = 64,
    parameter int LANE_W = 8,
    parameter int AW     = 5,
    parameter int NSRC   = 3
);
    localparam int LANES = DATA_W / LANE_W;

    logic                     i_id_valid;
    logic                     i_id_flush;
    logic                     i_id_wr;
    logic                     i_id_is_load;
    logic [AW-1:0]            i_id_rd;
    logic [2:0]               i_id_ppp;
    logic [NSRC*AW-1:0]       i_id_src;
    logic [NSRC-1:0]          i_id_src_used;
    logic [NSRC*DATA_W-1:0]   i_rf_data;
    logic                     i_ex_valid;
    logic [AW-1:0]            i_ex_rd;
    logic [2:0]               i_ex_ppp;
    logic [DATA_W-1:0]        i_ex_data;
    logic                     i_wb_valid;
    logic [AW-1:0]            i_wb_rd;
    logic [2:0]               i_wb_ppp;
    logic [DATA_W-1:0]        i_wb_data;
    logic                     o_stall;
    logic                     o_issue;
    logic [NSRC*DATA_W-1:0]   o_opnd_data;
    logic [NSRC*LANES*2-1:0]  o_fwd_sel;
    logic [15:0]              o_stall_cycles;

    modport master (
        output i_id_valid, i_id_flush, i_id_wr, i_id_is_load, i_id_rd, i_id_ppp,
               i_id_src, i_id_src_used, i_rf_data,
               i_ex_valid, i_ex_rd, i_ex_ppp, i_ex_data,
               i_wb_valid, i_wb_rd, i_wb_ppp, i_wb_data,
        input  o_stall, o_issue, o_opnd_data, o_fwd_sel, o_stall_cycles
    );

    modport slave (
        input  i_id_valid, i_id_flush, i_id_wr, i_id_is_load, i_id_rd, i_id_ppp,
               i_id_src, i_id_src_used, i_rf_data,
               i_ex_valid, i_ex_rd, i_ex_ppp, i_ex_data,
               i_wb_valid, i_wb_rd, i_wb_ppp, i_wb_data,
        output o_stall, o_issue, o_opnd_data, o_fwd_sel, o_stall_cycles
    );

endinterface

// File: rtl/cardinal_fwd_scoreboard_lane_fwd_mux.sv
// Per-lane operand merge for one source: EX bypass beats WB bypass beats register file.
module cardinal_lane_fwd_mux
    import cardinal_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int LANE_W = 8,
    parameter int AW     = 5
) (
    input  logic [AW-1:0]                  i_src,
    input  logic [DATA_W-1:0]              i_rf_data,
    input  logic                           i_ex_valid,
    input  logic [AW-1:0]                  i_ex_rd,
    input  logic [2:0]                     i_ex_ppp,
    input  logic [DATA_W-1:0]              i_ex_data,
    input  logic                           i_wb_valid,
    input  logic [AW-1:0]                  i_wb_rd,
    input  logic [2:0]                     i_wb_ppp,
    input  logic [DATA_W-1:0]              i_wb_data,
    output logic [DATA_W-1:0]              o_data,
    output logic [2*(DATA_W/LANE_W)-1:0]   o_sel
);
    localparam int LANES = DATA_W / LANE_W;

    logic             w_ex_hit;
    logic             w_wb_hit;
    logic [LANES-1:0] w_ex_mask;
    logic [LANES-1:0] w_wb_mask;

    // r0 is hardwired, so a bypass addressed to it never overrides the register file
    assign w_ex_hit  = i_ex_valid && (i_src != '0) && (i_ex_rd == i_src);
    assign w_wb_hit  = i_wb_valid && (i_src != '0) && (i_wb_rd == i_src);
    assign w_ex_mask = LANES'(ppp_lane_mask(i_ex_ppp, LANES));
    assign w_wb_mask = LANES'(ppp_lane_mask(i_wb_ppp, LANES));

    always_comb begin
        o_data = i_rf_data;
        o_sel  = '0;
        for (int l = 0; l < LANES; l++) begin
            if (w_ex_hit && w_ex_mask[l]) begin
                o_data[DATA_W-1-l*LANE_W -: LANE_W] = i_ex_data[DATA_W-1-l*LANE_W -: LANE_W];
                o_sel[(LANES-1-l)*2 +: 2]           = FWD_EX;
            end else if (w_wb_hit && w_wb_mask[l]) begin
                o_data[DATA_W-1-l*LANE_W -: LANE_W] = i_wb_data[DATA_W-1-l*LANE_W -: LANE_W];
                o_sel[(LANES-1-l)*2 +: 2]           = FWD_WB;
            end else begin
                o_sel[(LANES-1-l)*2 +: 2]           = FWD_RF;
            end
        end
    end

endmodule

// File: rtl/cardinal_fwd_scoreboard.sv
// ID-stage hazard unit: per-register, per-lane countdown of in-flight writes drives the load-use
// stall; NSRC lane muxes merge EX/WB bypass data into the source operands.
module cardinal_fwd_scoreboard
    import cardinal_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int LANE_W = 8,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int NSRC   = 3,
    parameter int LD_LAT = 2
) (
    input  logic clk_sys,
    input  logic rst_n,
    cardinal_fwd_scoreboard_if.slave bus
);
    localparam int LANES = DATA_W / LANE_W;
    localparam logic [CNT_W-1:0] CNT_ALU  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(1 + LD_LAT);

    logic [CNT_W-1:0]        r_cnt     [NREG][LANES];
    logic [CNT_W-1:0]        w_cnt_nxt [NREG][LANES];
    logic [15:0]             r_stall_cycles;
    logic [AW-1:0]           w_src     [NSRC];
    logic [LANES-1:0]        w_wr_mask;
    logic [CNT_W-1:0]        w_new;
    logic                    w_stall;
    logic                    w_issue;
    logic                    w_sb_wr;
    logic [NSRC*DATA_W-1:0]  w_opnd;
    logic [NSRC*LANES*2-1:0] w_sel;

    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            w_src[s] = bus.i_id_src[(NSRC-1-s)*AW +: AW];
        end
    end

    // A lane with count 1 arrives on the EX bypass this cycle, so only counts above 1 must wait
    always_comb begin
        w_stall = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            if (bus.i_id_src_used[s] && (w_src[s] != '0)) begin
                for (int l = 0; l < LANES; l++) begin
                    if (r_cnt[w_src[s]][l] > CNT_W'(1)) begin
                        w_stall = 1'b1;
                    end
                end
            end
        end
        w_stall = w_stall & bus.i_id_valid & ~bus.i_id_flush;
    end

    assign w_issue   = bus.i_id_valid & ~bus.i_id_flush & ~w_stall;
    assign w_sb_wr   = w_issue & bus.i_id_wr & (bus.i_id_rd != '0);
    assign w_new     = bus.i_id_is_load ? CNT_LOAD : CNT_ALU;
    assign w_wr_mask = LANES'(ppp_lane_mask(bus.i_id_ppp, LANES));

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            for (int l = 0; l < LANES; l++) begin
                w_cnt_nxt[r][l] = (r_cnt[r][l] != '0) ? (r_cnt[r][l] - CNT_W'(1)) : '0;
                if (w_sb_wr && (bus.i_id_rd == AW'(r)) && w_wr_mask[l] && (w_cnt_nxt[r][l] < w_new)) begin
                    w_cnt_nxt[r][l] = w_new;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                for (int l = 0; l < LANES; l++) begin
                    r_cnt[r][l] <= '0;
                end
            end
            r_stall_cycles <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        cardinal_lane_fwd_mux #(
            .DATA_W (DATA_W),
            .LANE_W (LANE_W),
            .AW     (AW)
        ) u_mux (
            .i_src      (w_src[s]),
            .i_rf_data  (bus.i_rf_data[(NSRC-1-s)*DATA_W +: DATA_W]),
            .i_ex_valid (bus.i_ex_valid),
            .i_ex_rd    (bus.i_ex_rd),
            .i_ex_ppp   (bus.i_ex_ppp),
            .i_ex_data  (bus.i_ex_data),
            .i_wb_valid (bus.i_wb_valid),
            .i_wb_rd    (bus.i_wb_rd),
            .i_wb_ppp   (bus.i_wb_ppp),
            .i_wb_data  (bus.i_wb_data),
            .o_data     (w_opnd[(NSRC-1-s)*DATA_W +: DATA_W]),
            .o_sel      (w_sel[(NSRC-1-s)*LANES*2 +: LANES*2])
        );
    end

    assign bus.o_stall        = w_stall;
    assign bus.o_issue        = w_issue;
    assign bus.o_opnd_data    = w_opnd;
    assign bus.o_fwd_sel      = w_sel;
    assign bus.o_stall_cycles = r_stall_cycles;

endmodule
